// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU data port (0) has priority, the loader/debug port (1)
// wins after STARVE denied cycles. Reads block arbitration for LAT cycles; writes do not.
module mem_arbiter #(
   parameter int LAT    = 2,
   parameter int STARVE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] adr0,
   input  logic [31:0] adr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        stall0,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int LW = (LAT > 1) ? $clog2(LAT + 1) : 1;
   localparam int SW = (STARVE > 1) ? $clog2(STARVE + 1) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [LW-1:0]   r_lat_cnt;
   logic [LW-1:0]   w_lat_nxt;
   logic [SW-1:0]   r_starve_cnt;
   logic [SW-1:0]   w_starve_nxt;
   logic            r_owner;
   logic            w_owner_nxt;
   logic            w_gnt0;
   logic            w_gnt1;
   logic            w_done;
   logic            w_starved;
   logic            r_rvalid0;
   logic            r_rvalid1;
   logic [31:0]     r_rdata0;
   logic [31:0]     r_rdata1;

   assign w_starved = (r_starve_cnt == SW'(STARVE));

   // Arbitration, memory strobe muxing and next-state computation
   always_comb begin
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      w_done       = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_adr      = 32'h0000_0000;
      mem_wdata    = 32'h0000_0000;
      w_state_nxt  = r_state;
      w_lat_nxt    = r_lat_cnt;
      w_starve_nxt = r_starve_cnt;
      w_owner_nxt  = r_owner;
      case (r_state)
         IDLE: begin
            // No grant may leak out while reset is held, even though state already reads IDLE
            if (reset) begin
               if (req1 && (!req0 || w_starved)) begin
                  w_gnt1 = 1'b1;
               end else if (req0) begin
                  w_gnt0 = 1'b1;
               end else begin
                  w_gnt0 = 1'b0;
               end
            end else begin
               w_gnt0 = 1'b0;
            end

            if (w_gnt1) begin
               mem_en    = 1'b1;
               mem_we    = we1;
               mem_adr   = adr1;
               mem_wdata = wdata1;
            end else if (w_gnt0) begin
               mem_en    = 1'b1;
               mem_we    = we0;
               mem_adr   = adr0;
               mem_wdata = wdata0;
            end else begin
               mem_en    = 1'b0;
            end

            if (w_gnt1 || !req1) begin
               w_starve_nxt = {SW{1'b0}};
            end else if (!w_starved) begin
               w_starve_nxt = r_starve_cnt + SW'(1);
            end else begin
               w_starve_nxt = r_starve_cnt;
            end

            if ((w_gnt0 && !we0) || (w_gnt1 && !we1)) begin
               w_state_nxt = BUSY;
               w_lat_nxt   = LW'(LAT);
               w_owner_nxt = w_gnt1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         BUSY: begin
            w_lat_nxt = r_lat_cnt - LW'(1);
            if (r_lat_cnt == LW'(1)) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = BUSY;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM, counters and owner tracking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_lat_cnt    <= {LW{1'b0}};
         r_starve_cnt <= {SW{1'b0}};
         r_owner      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_lat_cnt    <= w_lat_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_owner      <= w_owner_nxt;
      end
   end

   // Read-return capture; only the owner's data register is touched
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rdata0  <= 32'h0000_0000;
         r_rdata1  <= 32'h0000_0000;
      end else begin
         r_rvalid0 <= w_done && !r_owner;
         r_rvalid1 <= w_done && r_owner;
         if (w_done && !r_owner) begin
            r_rdata0 <= mem_rdata;
         end else begin
            r_rdata0 <= r_rdata0;
         end
         if (w_done && r_owner) begin
            r_rdata1 <= mem_rdata;
         end else begin
            r_rdata1 <= r_rdata1;
         end
      end
   end

   assign gnt0    = w_gnt0;
   assign gnt1    = w_gnt1;
   assign stall0  = req0 & ~w_gnt0;
   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter: per-cycle vectors check combinational outputs,
// a read scoreboard checks registered rvalid/rdata timing and values.
module tb_mem_arbiter;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [31:0] adr0, adr1, wdata0, wdata1;
   logic        gnt0, gnt1, stall0, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;
   logic        mem_en, mem_we;
   logic [31:0] mem_adr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.LAT(LAT), .STARVE(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        rst;
      logic        r0, w0;
      logic [31:0] a0, d0;
      logic        r1, w1;
      logic [31:0] a1, d1;
      logic [31:0] mrd;
      logic [4:0]  e_ctl;   // {gnt0, gnt1, stall0, mem_en, mem_we}
      logic [31:0] e_adr, e_wd;
   } vec_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
      int          due;
   } rd_t;

   vec_t        vecs[$];
   rd_t         sb[$];
   logic [31:0] exp_rd0, exp_rd1;
   int          n_total = 0;
   int          n_pass  = 0;

   function automatic vec_t mk(input logic rst, input logic r0, input logic w0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic [31:0] mrd, input logic [4:0] e_ctl,
                               input logic [31:0] e_adr, input logic [31:0] e_wd);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.mrd = mrd;
      v.e_ctl = e_ctl; v.e_adr = e_adr; v.e_wd = e_wd;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic check_regs(input int c);
      logic e_v0, e_v1;
      rd_t  r;
      e_v0 = 1'b0;
      e_v1 = 1'b0;
      if (sb.size() > 0 && sb[0].due == c) begin
         r = sb.pop_front();
         if (r.port) begin e_v1 = 1'b1; exp_rd1 = r.data; end
         else        begin e_v0 = 1'b1; exp_rd0 = r.data; end
      end
      check($sformatf("cyc%0d rvalid", c), {126'd0, rvalid0, rvalid1}, {126'd0, e_v0, e_v1});
      check($sformatf("cyc%0d rdata", c), {64'd0, rdata0, rdata1}, {64'd0, exp_rd0, exp_rd1});
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst;
      req0 = v.r0; we0 = v.w0; adr0 = v.a0; wdata0 = v.d0;
      req1 = v.r1; we1 = v.w1; adr1 = v.a1; wdata1 = v.d1;
      mem_rdata = v.mrd;
   endtask

   initial begin
      vec_t z;
      rd_t  e;
      int   n;
      reset = 1'b0;
      req0 = 1'b0; we0 = 1'b0; adr0 = 32'd0; wdata0 = 32'd0;
      req1 = 1'b0; we1 = 1'b0; adr1 = 32'd0; wdata1 = 32'd0;
      mem_rdata = 32'd0;
      exp_rd0 = 32'd0;
      exp_rd1 = 32'd0;

      // reset held with requests pending
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b00100, 32'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h80, 32'h9, 32'h0, 5'b00100, 32'h0, 32'h0));
      // first cycle after reset: back-to-back writes
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h64, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10011, 32'h64, 32'h7));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h68, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10011, 32'h68, 32'h8));
      // port-0 read, then port-0 write stalled during BUSY
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10010, 32'h10, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h20, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b00100, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h20, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 5'b00100, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h20, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10011, 32'h20, 32'h5));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hAA, 32'h0, 5'b01011, 32'h40, 32'hAA));
      // starvation: both ports writing continuously
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h100, 32'h1, 1'b1, 1'b1, 32'h200, 32'h2, 32'h0, 5'b10011, 32'h100, 32'h1));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h100, 32'h1, 1'b1, 1'b1, 32'h200, 32'h2, 32'h0, 5'b01111, 32'h200, 32'h2));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h100, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10011, 32'h100, 32'h1));
      // port-1 read with port 0 contending during BUSY
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 5'b01010, 32'h300, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h120, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b00100, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h120, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 5'b00100, 32'h0, 32'h0));
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h120, 32'h3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10011, 32'h120, 32'h3));
      // port-0 read must leave rdata1 untouched
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10010, 32'h30, 32'h0));
      z = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0, 32'h0);
      vecs.push_back(z);
      z.mrd = 32'h12345678;
      vecs.push_back(z);
      z.mrd = 32'h0;
      vecs.push_back(z);
      // reset in the middle of a port-1 read
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 5'b01010, 32'h44, 32'h0));
      z.rst = 1'b0;
      vecs.push_back(z);
      z.mrd = 32'h0BAD0BAD;
      vecs.push_back(z);
      z.rst = 1'b1;
      z.mrd = 32'h0;
      vecs.push_back(z);
      vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h50, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10011, 32'h50, 32'h11));
      vecs.push_back(z);
      vecs.push_back(z);

      n = vecs.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_regs(i);
         drive(vecs[i]);
         if (!vecs[i].rst) begin
            sb.delete();
            exp_rd0 = 32'd0;
            exp_rd1 = 32'd0;
         end
         @(negedge clk);
         check($sformatf("row%0d comb", i),
               {59'd0, gnt0, gnt1, stall0, mem_en, mem_we, mem_adr, mem_wdata},
               {59'd0, vecs[i].e_ctl, vecs[i].e_adr, vecs[i].e_wd});
         if (vecs[i].e_ctl[1] && !vecs[i].e_ctl[0] && (i + LAT) < n) begin
            e.port = vecs[i].e_ctl[3];
            e.data = vecs[i + LAT].mrd;
            e.due  = i + LAT + 1;
            sb.push_back(e);
         end
      end
      for (int i = n; i < n + 4; i++) begin
         @(posedge clk);
         #1;
         check_regs(i);
      end
      check("scoreboard drained", {96'd0, 32'(sb.size())}, 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
